// File: rtl/instr_fetch_queue.sv
// Fetch front end: issues word fetches to the I-cache and queues {word, pc} for decode; head visible 1 cycle after return.
// Decode backpressure via freeze/not-ready stops pops only; fetching continues until the queue is full.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       Request_Alt_PC_IN,
  input  logic [31:0]                Alt_PC_IN,
  input  logic                       WANT_FREEZE_IN,
  input  logic                       Request_Instr1_IN,
  output logic                       IC_Req_OUT,
  output logic [31:0]                IC_Addr_OUT,
  input  logic                       IC_Valid_IN,
  input  logic [31:0]                IC_Data_IN,
  output logic [31:0]                Instr1_OUT,
  output logic                       Instr1_Valid_OUT,
  output logic [31:0]                Instr_PC_OUT,
  output logic [31:0]                Instr_PC_Plus4_OUT,
  output logic [$clog2(DEPTH):0]     Queue_Count_OUT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pp;
  state_t        st_q, st_d;
  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d, addr_q, addr_d;
  logic          pend_q, pend_d, req_q, req_d;
  logic          pop, ret, push, redir_now;

  assign pop    = Request_Instr1_IN && !WANT_FREEZE_IN && (cnt_q != '0);
  assign ret    = req_q && IC_Valid_IN;
  assign push   = ret && (st_q == S_WAIT);
  assign cnt_pp = cnt_q - CW'(pop) + CW'(push);
  // A redirect acts immediately once the delay slot is already in hand (popped or at the head).
  assign redir_now = Request_Alt_PC_IN && (pop || (cnt_pp != '0));

  always_comb begin
    rd_d   = rd_q + PW'(pop);
    wr_d   = wr_q + PW'(push);
    cnt_d  = cnt_pp;
    fpc_d  = fpc_q;
    pend_d = pend_q;
    rpc_d  = rpc_q;
    st_d   = st_q;
    req_d  = req_q;
    addr_d = addr_q;

    if (push) begin
      if (pend_q) begin
        fpc_d  = rpc_q;
        pend_d = 1'b0;
      end else begin
        fpc_d = addr_q + 32'd4;
      end
    end

    if (Request_Alt_PC_IN) begin
      if (redir_now) begin
        fpc_d  = Alt_PC_IN;
        pend_d = 1'b0;
        cnt_d  = pop ? '0 : CW'(1);
        wr_d   = rd_d + PW'(!pop);
      end else begin
        pend_d = 1'b1;
        rpc_d  = Alt_PC_IN;
      end
    end

    if (st_q == S_IDLE || ret) begin
      if (cnt_d < CW'(DEPTH)) begin
        req_d  = 1'b1;
        addr_d = fpc_d;
        st_d   = S_WAIT;
      end else begin
        req_d = 1'b0;
        st_d  = S_IDLE;
      end
    end else if (redir_now) begin
      st_d = S_DISCARD;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      st_q   <= S_IDLE;
      fpc_q  <= RESET_PC;
      pend_q <= 1'b0;
      rpc_q  <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      fpc_q  <= fpc_d;
      pend_q <= pend_d;
      rpc_q  <= rpc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= '{word: IC_Data_IN, pc: addr_q};
  end

  assign head               = mem_q[rd_q];
  assign Instr1_Valid_OUT   = (cnt_q != '0);
  assign Instr1_OUT         = Instr1_Valid_OUT ? head.word : '0;
  assign Instr_PC_OUT       = Instr1_Valid_OUT ? head.pc : '0;
  assign Instr_PC_Plus4_OUT = Instr1_Valid_OUT ? head.pc + 32'd4 : '0;
  assign Queue_Count_OUT    = cnt_q;
  assign IC_Req_OUT         = req_q;
  assign IC_Addr_OUT        = addr_q;

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Front-end fetch unit and instruction queue feeding the decode stage. It issues word fetches to the instruction cache and buffers returned words with their PCs in a small FIFO. It presents the FIFO head to decode with a valid flag and pops on decode's request. It applies branch/jump redirects from decode, preserving exactly one delay-slot instruction.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0040_0000, address of first fetch after reset
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  reset, asynchronous, active-low
- Request_Alt_PC_IN  in  1  redirect request from decode (one-cycle pulse)
- Alt_PC_IN  in  32  redirect target, word-aligned
- WANT_FREEZE_IN  in  1  decode freeze; blocks pop
- Request_Instr1_IN  in  1  decode ready to consume head
- IC_Req_OUT  out  1  fetch request outstanding to I-cache
- IC_Addr_OUT  out  32  fetch address; stable while IC_Req_OUT=1
- IC_Valid_IN  in  1  fetch data valid; ignored when IC_Req_OUT=0
- IC_Data_IN  in  32  fetched word
- Instr1_OUT  out  32  head instruction; 0 when empty
- Instr1_Valid_OUT  out  1  head valid (queue non-empty)
- Instr_PC_OUT  out  32  PC of head; 0 when empty
- Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4; 0 when empty
- Queue_Count_OUT  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: FPC (next fetch address), FIFO of {word, pc}, count, fetch FSM {IDLE, WAIT, DISCARD}, RedirPending + RedirPC.
- Reset: FIFO empty, count=0, FSM=IDLE, FPC=RESET_PC, RedirPending=0, IC_Req_OUT=0, IC_Addr_OUT=0, all head outputs 0.
- Head outputs are combinational from FIFO head. Instr1_Valid_OUT = (count≠0).
- Pop at edge when Request_Instr1_IN && !WANT_FREEZE_IN && count≠0.
- Issue: in IDLE, or in WAIT on a return edge, if count_after_edge < DEPTH. The new request uses IC_Addr_OUT<=FPC and IC_Req_OUT<=1, and the FSM enters or stays in WAIT. Otherwise the FSM goes to IDLE and IC_Req_OUT<=0.
- Return in WAIT (IC_Valid_IN=1): push {IC_Data_IN, IC_Addr_OUT}. FPC<=IC_Addr_OUT+4, unless RedirPending is set, in which case FPC<=RedirPC and RedirPending is cleared.
- Return in DISCARD: drop the word, no push, FPC unchanged. Issue rule applies in the same edge.
- Redirect edge (Request_Alt_PC_IN=1), cases by pop/count/FSM:
  - Pop this edge: popped word is the delay slot. Flush all remaining entries. FPC<=Alt_PC_IN. Outstanding fetch → DISCARD.
  - No pop, count≥1: keep head only (delay slot), count=1. FPC<=Alt_PC_IN. Outstanding fetch → DISCARD.
  - No pop, count=0, WAIT: outstanding word is the delay slot and is kept. RedirPending<=1, RedirPC<=Alt_PC_IN.
  - No pop, count=0, IDLE: next fetch at FPC is the delay slot. RedirPending<=1, RedirPC<=Alt_PC_IN.
- Simultaneous redirect and return in WAIT: the returned word counts as outstanding-resolved. Apply the pop/count cases using the post-push queue. The pushed word is kept only if it becomes the head.
- Redirect while RedirPending: newer RedirPC overwrites.
- Freeze does not block fetching; the queue fills to DEPTH and then stops issuing.
- Arithmetic: PCs mod 2^32; FFFF_FFFC+4 wraps to 0.

## Timing
- First IC_Req_OUT rises at the first posedge after RESET deasserts, with IC_Addr_OUT=RESET_PC.
- Zero-wait cache (IC_Valid_IN high in first request cycle): one word per cycle. Word pushed at edge N is visible on the head at cycle N+1.
- Full: when count=DEPTH with no outstanding fetch, IC_Req_OUT=0. A pop re-enables issue on the same edge.
- Fetch-to-decode latency: 1 cycle after the return edge.
- RESET assertion mid-fetch: immediate clear. Any later IC_Valid_IN is ignored because IC_Req_OUT=0.

## Test plan
- Reset, then zero-wait cache returning word=addr, decode always ready: head PCs 0040_0000, _0004, _0008 on consecutive cycles, with Instr_PC_Plus4_OUT = PC+4.
- WANT_FREEZE_IN held high with DEPTH=4: count reaches 4 and IC_Req_OUT drops. Releasing freeze pops one entry and re-issues at 0040_0010.
- Redirect to 0040_1000 with pop while count=3: after the edge count=0 or 1 (new fetch pending). The next head PC is 0040_1000; entries 0040_0008/000C are never presented.
- Redirect with empty queue and a 3-cycle-latency fetch outstanding for 0040_0004: 0040_0004 is presented next, followed by 0040_2000.
- Redirect with count=2 and freeze high: count becomes 1. The head (delay slot) is retained, and the in-flight return is discarded.
- Async RESET low during WAIT: all outputs 0 immediately. A stale IC_Valid_IN pulse afterwards produces no push.
